stream_mux: RTL
===============

Name: stream_mux

Overview:
- Parametrised successor to the 2:1 combinational datapath mux.
- Selects one of N valid/ready input streams of WIDTH bits into a single registered output stream.
- Two selection modes: fixed (external sel, as the old mux) and round-robin fair arbitration.
- Feeds the factorial datapath, e.g. choosing operand/feedback sources, with back-pressure support.

Parameters:
- WIDTH, 8, data width of each channel and of the output.
- N, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(N), width of sel/out_ch. Local, derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; one-hot or zero.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts.
- out_ch  output  SEL_W  source channel of the word in out_data.

Behaviour:
- Clocking and reset: single clock domain. Async reset is asserted on the falling edge of rst_n and released synchronously by the design's reset tree.
- Reset values: out_valid=0, out_data=0, out_ch=0, RR pointer last=N-1, so channel 0 has first priority after reset.
- One-entry output register: can_accept = !out_valid | out_ready.
- Fixed mode (mode=0):
  - grant = sel when in_valid[sel]=1 and sel<N.
  - Otherwise no grant; no other channel is served.
- Round-robin mode (mode=1):
  - Search in_valid starting at (last+1) mod N, wrapping; the first set bit wins.
  - last updates to the granted index only on an accepted transfer. It holds otherwise, including during stalls.
- in_ready[i] = can_accept & grant_valid & (grant==i). Purely combinational from state and inputs.
  - in_ready must not depend on out_ready when out_valid=0.
- Transfer on channel i when in_valid[i] & in_ready[i]. At the next edge: out_data <= channel i data, out_ch <= i, out_valid <= 1.
- Latency: exactly 1 cycle from input handshake to out_valid.
- Throughput: 1 word per cycle when out_ready stays high.
- Drain: out_valid & out_ready with no new transfer → out_valid <= 0. out_data and out_ch hold their last value.
- Stall: out_valid & !out_ready → out_data, out_ch, out_valid frozen; all in_ready=0.
- Simultaneous drain and new transfer in one cycle: the new word replaces the old one; out_valid stays 1, with no bubble.
- Mode or sel change mid-stream: takes effect on the next grant decision. The held output word is unaffected, and last is not reset.
- sel>=N (possible only when N is not a power of two): no grant, in_ready=0.
- Reset mid-transfer: the word in flight is discarded; all outputs return to reset values immediately.
- No combinational path from in_data to out_data.

Decomposition:
- Shared package (mux_pkg) holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 constants.
  - A function computing the round-robin next index from a valid vector and a start index. The bench reuses it as its reference model.
- One natural sub-module: rr_arbiter (N parameter). Inputs: req[N], last[SEL_W]. Outputs: grant_valid, grant[SEL_W]. Purely combinational.
- Top level keeps the mode mux, the ready generation, the output register and the last pointer.

Test Plan (WIDTH=8, N=4):
1. Fixed select, two cases, out_ready=1:
   - mode=0, sel=1, in_valid=4'b0110, ch1=8'hF0, ch2=8'h0F → next cycle out_data=8'hF0, out_ch=1; in_ready=4'b0010.
   - sel=2 → out_data=8'h0F, out_ch=2.
2. Round-robin fairness: mode=1, all in_valid=1, data chN=8'hA0+N, out_ready=1 for 6 cycles → out_ch sequence 0,1,2,3,0,1, one word per cycle with no bubbles.
3. Back-pressure: mode=1, ch0,ch2 valid, out_ready=0 for 3 cycles after first word (8'hA0):
   - out_data holds 8'hA0 and in_ready=0 throughout.
   - On out_ready=1, ch2 is granted the same cycle; out_data=8'hA2 on the next cycle.
4. Fixed mode, unselected requester: mode=0, sel=3, in_valid=4'b0001 → in_ready=0 and out_valid stays 0 for 5 cycles. Then in_valid[3]=1 with ch3=8'h55 → out_data=8'h55.
5. Mode switch preserves the pointer: RR grants ch0 and ch1, then mode=0, sel=3 for one word, then mode=1 with all valid → next RR grant is ch2.
6. Reset mid-stream: assert rst_n=0 while out_valid=1, out_data=8'hA3 → out_valid=0, out_data=0, out_ch=0 immediately. After release, all valid in RR mode → first grant is ch0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and the round-robin pick function for stream_mux.
// The pick function is also the bench's reference model.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   MAX_N      = 16;

  // Returns {found, index}; search starts at last+1 and wraps at n.
  function automatic logic [4:0] rr_pick(
    input logic [15:0] req,
    input logic [3:0]  last,
    input int          n
  );
    logic [4:0] r;
    int idx;
    r = '0;
    for (int k = MAX_N; k >= 1; k--) begin
      if (k <= n) begin
        idx = int'(last) + k;
        if (idx >= n) idx = idx - n;
        if (req[4'(idx)]) r = {1'b1, 4'(idx)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter over N requests.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant
);

  logic [4:0] pick;

  assign pick        = rr_pick(16'(req), 4'(last), N);
  assign grant_valid = pick[4];
  assign grant       = SEL_W'(pick[3:0]);

endmodule

// File: rtl/stream_mux.sv
// N:1 valid/ready stream mux, fixed or round-robin select,
// single registered output stage.
module stream_mux
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_ch
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             valid_q, valid_d;

  logic             rr_gv;
  logic [SEL_W-1:0] rr_g;
  logic             gv;
  logic [SEL_W-1:0] g;
  logic             sel_ok;
  logic             can_accept;
  logic             xfer;

  rr_arbiter #(.N(N)) u_arb (
    .req         (in_valid),
    .last        (last_q),
    .grant_valid (rr_gv),
    .grant       (rr_g)
  );

  // sel can exceed N-1 only when N is not a power of two
  assign sel_ok = 32'(sel) < N;

  always_comb begin
    gv = 1'b0;
    g  = '0;
    if (mode == MODE_RR) begin
      gv = rr_gv;
      g  = rr_g;
    end else begin
      gv = sel_ok & in_valid[sel];
      g  = sel;
    end
  end

  assign can_accept = !valid_q | out_ready;
  assign xfer       = can_accept & gv;
  assign in_ready   = xfer ? (N'(1) << g) : '0;

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (xfer) begin
      data_d  = in_data[g*WIDTH +: WIDTH];
      ch_d    = g;
      valid_d = 1'b1;
      if (mode == MODE_RR) last_d = g;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= SEL_W'(N - 1);
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;

endmodule
